multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Moore-style sequencer for the multicycle variant of the RV32I core (lw, sw, R-type, I-type ALU, beq, jal). The datapath shares one ALU and one unified instruction/data memory port; this block steps it through fetch, decode, execute, memory and writeback.
It adds a request/ready handshake so memory may take a variable number of cycles, a bounded-wait watchdog, and a sticky trap state for illegal encodings.

Parameters:
MEM_WAIT_MAX, 15, maximum consecutive cycles a memory state may wait for mem_ready before trapping; legal range 1..255.

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
op  input  7  Instr[6:0], valid from DECODE onward (IR register)
funct3  input  3  Instr[14:12]
funct7b5  input  1  Instr[30]
zero  input  1  ALU zero flag
mem_ready  input  1  memory completes the current access this cycle
mem_req  output  1  memory access request
mem_write  output  1  store strobe, valid only with mem_req
adr_src  output  1  0 = PC, 1 = ALUOut
ir_write  output  1  load IR and OldPC
pc_write  output  1  load PC from Result
reg_write  output  1  register file write enable
result_src  output  2  00 ALUOut, 01 Data, 10 ALUResult
alu_src_a  output  2  00 PC, 01 OldPC, 10 rs1 reg
alu_src_b  output  2  00 rs2 reg, 01 ImmExt, 10 constant 4
alu_control  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
imm_src  output  2  00 I, 01 S, 10 B, 11 J; decoded combinationally from op
trap  output  1  sticky illegal-instruction or memory-timeout flag
state_o  output  4  current state, for debug

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10, TRAP=15.
- Reset: state goes to FETCH and the wait counter clears. While reset is high, mem_req, mem_write, ir_write, pc_write and reg_write are forced to 0 and trap is 0.
- All strobes are combinational from state, plus mem_ready, zero, op, funct3 and funct7b5. Unlisted outputs in a state are 0.
- FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, add, result_src=10.
  - ir_write=1 and pc_write=1 only in the cycle where mem_ready=1; that same cycle the state moves to DECODE.
  - Otherwise FETCH holds.
- DECODE: alu_src_a=01, alu_src_b=01, add (branch/jump target into ALUOut). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - anything else -> TRAP
  - R/I-type with funct3 not in {000, 010, 110, 111} -> TRAP
  - beq with funct3 != 000 -> TRAP
- MEMADR: alu_src_a=10, alu_src_b=01, add. Goes to MEMREAD if op[5]=0, otherwise MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1. Holds until mem_ready, then MEMWB.
- MEMWB: result_src=01, reg_write=1, then FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1. Holds until mem_ready, then FETCH.
- EXECR and EXECI: alu_src_a=10; alu_src_b is 00 in EXECR and 01 in EXECI; ALU decode as below. Both go to ALUWB.
- ALUWB: result_src=00, reg_write=1, then FETCH.
- BEQ: alu_src_a=10, alu_src_b=00, sub, result_src=00, pc_write=zero, then FETCH.
- JAL: alu_src_a=01, alu_src_b=10, add, result_src=00, pc_write=1, then ALUWB.
- ALU decode in EXECR/EXECI:
  - funct3 000 -> sub if funct7b5 & op[5], otherwise add
  - 010 -> slt
  - 110 -> or
  - 111 -> and
- Wait counter:
  - Width is enough to hold MEM_WAIT_MAX.
  - Increments each cycle spent in FETCH, MEMREAD or MEMWRITE with mem_ready=0.
  - Clears on mem_ready=1 or on leaving a wait state.
  - If mem_ready=0 when the counter already equals MEM_WAIT_MAX, the next state is TRAP.
  - A mem_ready=1 arriving in that same cycle wins and the access completes.
- TRAP: all strobes 0, trap=1. Only reset leaves TRAP.
- Reset asserted mid-access returns to FETCH immediately; the in-flight access is abandoned with no strobe.

Optional Feature:
RETIRE_CNT_EN:
- When defined, adds output instret (32 bits), reset to 0.
- instret increments by 1 on every transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ, and wraps at 2^32.
- When undefined, the port and counter are absent.

Test Plan:
- lw 0x00402283 with mem_ready tied 1 -> states 0,1,2,3,4,0 over 5 cycles; reg_write=1 only in cycle 5 with result_src=01.
- sub 0x40628233 -> EXECR shows alu_control=001; add 0x00628233 shows 000; each instruction takes 4 cycles.
- beq 0x00000463 with zero=1 -> pc_write=1 in the BEQ cycle; with zero=0 -> pc_write=0, then back to FETCH.
- Fetch with mem_ready low for 3 cycles then high -> FETCH held for 4 cycles; ir_write and pc_write pulse once, in the 4th cycle only.
- mem_ready held low with MEM_WAIT_MAX=15 -> TRAP after 16 FETCH cycles, trap=1, mem_req=0; reset then returns to FETCH with trap=0.
- op 0x7F -> DECODE then TRAP. With RETIRE_CNT_EN defined, sw, jal, beq then lw -> instret=4 and unchanged by the trap.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - control/datapath bundle between the multicycle sequencer and its datapath
// Optional RETIRE_CNT_EN adds the instret retire counter to the bundle.

interface multicycle_ctrl_if;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        zero;
    logic        mem_ready;

    logic        mem_req;
    logic        mem_write;
    logic        adr_src;
    logic        ir_write;
    logic        pc_write;
    logic        reg_write;
    logic [1:0]  result_src;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [2:0]  alu_control;
    logic [1:0]  imm_src;
    logic        trap;
    logic [3:0]  state_o;
`ifdef RETIRE_CNT_EN
    logic [31:0] instret;
`endif

    // controller side: consumes instruction fields and flags, drives strobes
    modport master (
`ifdef RETIRE_CNT_EN
        output instret,
`endif
        input  op, funct3, funct7b5, zero, mem_ready,
        output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
        output result_src, alu_src_a, alu_src_b, alu_control, imm_src,
        output trap, state_o
    );

    // datapath side: the mirror image
    modport slave (
`ifdef RETIRE_CNT_EN
        input  instret,
`endif
        output op, funct3, funct7b5, zero, mem_ready,
        input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
        input  result_src, alu_src_a, alu_src_b, alu_control, imm_src,
        input  trap, state_o
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - Moore sequencer for the multicycle RV32I core with memory handshake, watchdog and trap
// Optional RETIRE_CNT_EN adds a 32-bit retired-instruction counter (instret).

module multicycle_ctrl #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              reset,
    multicycle_ctrl_if.master bus
);

    localparam int CW = $clog2(MEM_WAIT_MAX + 1);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    state_t        r_state;
    state_t        w_next_state;
    logic [CW-1:0] r_wait_cnt;
    logic [CW-1:0] w_wait_cnt_next;

    logic          w_in_wait;
    logic          w_timeout;
    logic          w_alu_f3_ok;
    logic [2:0]    w_alu_dec;

    logic          w_mem_req;
    logic          w_mem_write;
    logic          w_adr_src;
    logic          w_ir_write;
    logic          w_pc_write;
    logic          w_reg_write;
    logic [1:0]    w_result_src;
    logic [1:0]    w_alu_src_a;
    logic [1:0]    w_alu_src_b;
    logic [2:0]    w_alu_control;
    logic [1:0]    w_imm_src;

    // Only the three memory-facing states can stall on mem_ready; the
    // watchdog fires when the counter is already at its limit and memory is
    // still not ready (a late mem_ready in that same cycle still wins).
    assign w_in_wait = (r_state == S_FETCH) || (r_state == S_MEMREAD) ||
                       (r_state == S_MEMWRITE);
    assign w_timeout = w_in_wait && !bus.mem_ready &&
                       (r_wait_cnt == CW'(MEM_WAIT_MAX));
    assign w_wait_cnt_next = (w_in_wait && !bus.mem_ready && !w_timeout) ?
                             r_wait_cnt + CW'(1) : '0;

    // state register with asynchronous reset back to FETCH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // consecutive-stall counter for the memory watchdog
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= w_wait_cnt_next;
        end
    end

    // ALU operation for R/I-type execute and legality of their funct3
    always_comb begin
        w_alu_dec   = ALU_ADD;
        w_alu_f3_ok = 1'b1;
        case (bus.funct3)
            3'b000:  w_alu_dec = (bus.funct7b5 && bus.op[5]) ? ALU_SUB : ALU_ADD;
            3'b010:  w_alu_dec = ALU_SLT;
            3'b110:  w_alu_dec = ALU_OR;
            3'b111:  w_alu_dec = ALU_AND;
            default: w_alu_f3_ok = 1'b0;
        endcase
    end

    // immediate format follows the opcode directly, independent of state
    always_comb begin
        w_imm_src = 2'b00;
        case (bus.op)
            OP_STORE: w_imm_src = 2'b01;
            OP_BEQ:   w_imm_src = 2'b10;
            OP_JAL:   w_imm_src = 2'b11;
            default:  w_imm_src = 2'b00;
        endcase
    end

    // next-state and per-state datapath controls
    always_comb begin
        w_next_state  = r_state;
        w_mem_req     = 1'b0;
        w_mem_write   = 1'b0;
        w_adr_src     = 1'b0;
        w_ir_write    = 1'b0;
        w_pc_write    = 1'b0;
        w_reg_write   = 1'b0;
        w_result_src  = 2'b00;
        w_alu_src_a   = 2'b00;
        w_alu_src_b   = 2'b00;
        w_alu_control = ALU_ADD;
        case (r_state)
            S_FETCH: begin
                w_mem_req    = 1'b1;
                w_alu_src_b  = 2'b10;
                w_result_src = 2'b10;
                if (bus.mem_ready) begin
                    w_ir_write   = 1'b1;
                    w_pc_write   = 1'b1;
                    w_next_state = S_DECODE;
                end else if (w_timeout) begin
                    w_next_state = S_TRAP;
                end
            end
            S_DECODE: begin
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b01;
                case (bus.op)
                    OP_LOAD, OP_STORE: w_next_state = S_MEMADR;
                    OP_RTYPE: w_next_state = w_alu_f3_ok ? S_EXECR : S_TRAP;
                    OP_ITYPE: w_next_state = w_alu_f3_ok ? S_EXECI : S_TRAP;
                    OP_BEQ:   w_next_state = (bus.funct3 == 3'b000) ? S_BEQ : S_TRAP;
                    OP_JAL:   w_next_state = S_JAL;
                    default:  w_next_state = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                w_alu_src_a  = 2'b10;
                w_alu_src_b  = 2'b01;
                w_next_state = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                w_mem_req = 1'b1;
                w_adr_src = 1'b1;
                if (bus.mem_ready) begin
                    w_next_state = S_MEMWB;
                end else if (w_timeout) begin
                    w_next_state = S_TRAP;
                end
            end
            S_MEMWB: begin
                w_result_src = 2'b01;
                w_reg_write  = 1'b1;
                w_next_state = S_FETCH;
            end
            S_MEMWRITE: begin
                w_mem_req   = 1'b1;
                w_mem_write = 1'b1;
                w_adr_src   = 1'b1;
                if (bus.mem_ready) begin
                    w_next_state = S_FETCH;
                end else if (w_timeout) begin
                    w_next_state = S_TRAP;
                end
            end
            S_EXECR: begin
                w_alu_src_a   = 2'b10;
                w_alu_src_b   = 2'b00;
                w_alu_control = w_alu_dec;
                w_next_state  = S_ALUWB;
            end
            S_EXECI: begin
                w_alu_src_a   = 2'b10;
                w_alu_src_b   = 2'b01;
                w_alu_control = w_alu_dec;
                w_next_state  = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write  = 1'b1;
                w_next_state = S_FETCH;
            end
            S_BEQ: begin
                w_alu_src_a   = 2'b10;
                w_alu_control = ALU_SUB;
                w_pc_write    = bus.zero;
                w_next_state  = S_FETCH;
            end
            S_JAL: begin
                w_alu_src_a  = 2'b01;
                w_alu_src_b  = 2'b10;
                w_pc_write   = 1'b1;
                w_next_state = S_ALUWB;
            end
            S_TRAP: begin
                w_next_state = S_TRAP;
            end
            default: begin
                w_next_state = S_TRAP;
            end
        endcase
    end

`ifdef RETIRE_CNT_EN
    logic [31:0] r_instret;
    logic        w_retire;

    // an instruction retires on the step back to FETCH from its last state
    assign w_retire = (w_next_state == S_FETCH) &&
                      ((r_state == S_MEMWB) || (r_state == S_MEMWRITE) ||
                       (r_state == S_ALUWB) || (r_state == S_BEQ));

    // free-running retired-instruction count, wraps naturally at 2^32
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instret <= '0;
        end else if (w_retire) begin
            r_instret <= r_instret + 32'd1;
        end
    end

    assign bus.instret = r_instret;
`endif

    // Reset is asynchronous, so the side-effecting strobes are gated with it
    // directly; FETCH asserts mem_req and must not leak it during reset.
    assign bus.mem_req     = w_mem_req   & ~reset;
    assign bus.mem_write   = w_mem_write & ~reset;
    assign bus.ir_write    = w_ir_write  & ~reset;
    assign bus.pc_write    = w_pc_write  & ~reset;
    assign bus.reg_write   = w_reg_write & ~reset;
    assign bus.trap        = (r_state == S_TRAP) & ~reset;
    assign bus.adr_src     = w_adr_src;
    assign bus.result_src  = w_result_src;
    assign bus.alu_src_a   = w_alu_src_a;
    assign bus.alu_src_b   = w_alu_src_b;
    assign bus.alu_control = w_alu_control;
    assign bus.imm_src     = w_imm_src;
    assign bus.state_o     = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard testbench for multicycle_ctrl

module tb_multicycle_ctrl;

    typedef struct {
        logic       rdy;
        logic       zr;
        logic [3:0] st;
        logic [6:0] strb;
        logic [1:0] rs;
        logic [2:0] alu;
    } exp_t;

    // strobe vector order: {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, trap}
    localparam logic [6:0] SB_FETCH = 7'b1001100;
    localparam logic [6:0] SB_STALL = 7'b1000000;
    localparam logic [6:0] SB_NONE  = 7'b0000000;
    localparam logic [6:0] SB_MRD   = 7'b1010000;
    localparam logic [6:0] SB_MWR   = 7'b1110000;
    localparam logic [6:0] SB_WB    = 7'b0000010;
    localparam logic [6:0] SB_PCW   = 7'b0000100;
    localparam logic [6:0] SB_TRAP  = 7'b0000001;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_retired = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.MEM_WAIT_MAX(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [6:0] strobes();
        return {bus.mem_req, bus.mem_write, bus.adr_src, bus.ir_write,
                bus.pc_write, bus.reg_write, bus.trap};
    endfunction

    task automatic push(input logic rdy, input logic zr, input logic [3:0] st,
                        input logic [6:0] strb, input logic [1:0] rs, input logic [2:0] alu);
        exp_t e;
        e.rdy = rdy; e.zr = zr; e.st = st; e.strb = strb; e.rs = rs; e.alu = alu;
        sb.push_back(e);
    endtask

    task automatic set_instr(input logic [31:0] w);
        bus.op       = w[6:0];
        bus.funct3   = w[14:12];
        bus.funct7b5 = w[30];
        #1;
    endtask

    task automatic push_fetch(input int stalls);
        for (int i = 0; i < stalls; i++) push(1'b0, 1'b0, 4'd0, SB_STALL, 2'b10, 3'b000);
        push(1'b1, 1'b0, 4'd0, SB_FETCH, 2'b10, 3'b000);
        push(1'b1, 1'b0, 4'd1, SB_NONE, 2'b00, 3'b000);
    endtask

    // pops one expectation per clock, driving its inputs and comparing mid-cycle
    task automatic run_q(input string tag);
        exp_t e;
        int   cyc = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            bus.mem_ready = e.rdy;
            bus.zero      = e.zr;
            @(negedge clk);
            check($sformatf("%s c%0d state", tag, cyc), 32'(bus.state_o), 32'(e.st));
            check($sformatf("%s c%0d strobes", tag, cyc), 32'(strobes()), 32'(e.strb));
            check($sformatf("%s c%0d result_src", tag, cyc), 32'(bus.result_src), 32'(e.rs));
            check($sformatf("%s c%0d alu_control", tag, cyc), 32'(bus.alu_control), 32'(e.alu));
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("reset state", 32'(bus.state_o), 32'd0);
        check("reset strobes", 32'(strobes()), 32'd0);
`ifdef RETIRE_CNT_EN
        check("reset instret", bus.instret, 32'd0);
`endif
        n_retired = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic r_type(input string tag, input logic [31:0] w, input logic [3:0] ex_st,
                          input logic [2:0] alu, input int stalls);
        set_instr(w);
        push_fetch(stalls);
        push(1'b1, 1'b0, ex_st, SB_NONE, 2'b00, alu);
        push(1'b1, 1'b0, 4'd8, SB_WB, 2'b00, 3'b000);
        run_q(tag);
        n_retired++;
    endtask

    initial begin
        reset         = 1'b1;
        bus.mem_ready = 1'b0;
        bus.zero      = 1'b0;
        bus.op        = 7'h0;
        bus.funct3    = 3'h0;
        bus.funct7b5  = 1'b0;
        #12;
        do_reset();

        // lw: FETCH, DECODE, MEMADR, MEMREAD, MEMWB
        set_instr(32'h00402283);
        check("lw imm_src", 32'(bus.imm_src), 32'd0);
        push_fetch(0);
        push(1'b1, 1'b0, 4'd2, SB_NONE, 2'b00, 3'b000);
        push(1'b1, 1'b0, 4'd3, SB_MRD, 2'b00, 3'b000);
        push(1'b1, 1'b0, 4'd4, SB_WB, 2'b01, 3'b000);
        run_q("lw");
        n_retired++;

        r_type("sub",  32'h40628233, 4'd6, 3'b001, 0);
        r_type("add",  32'h00628233, 4'd6, 3'b000, 0);
        r_type("addi", 32'h40010093, 4'd7, 3'b000, 0);
        r_type("slt",  32'h0062a233, 4'd6, 3'b101, 0);
        r_type("or",   32'h0062e233, 4'd6, 3'b011, 0);
        r_type("andi", 32'h0ff17093, 4'd7, 3'b010, 0);

        // beq taken and not taken
        set_instr(32'h00000463);
        check("beq imm_src", 32'(bus.imm_src), 32'd2);
        push_fetch(0);
        push(1'b1, 1'b1, 4'd9, SB_PCW, 2'b00, 3'b001);
        push_fetch(0);
        push(1'b1, 1'b0, 4'd9, SB_NONE, 2'b00, 3'b001);
        run_q("beq");
        n_retired += 2;

        // fetch stalled 3 cycles, then the 15-stall boundary where ready wins
        r_type("stall3", 32'h00628233, 4'd6, 3'b000, 3);
        r_type("stall15", 32'h00628233, 4'd6, 3'b000, 15);

        // sw with one memory wait cycle
        set_instr(32'h0062a023);
        check("sw imm_src", 32'(bus.imm_src), 32'd1);
        push_fetch(0);
        push(1'b1, 1'b0, 4'd2, SB_NONE, 2'b00, 3'b000);
        push(1'b0, 1'b0, 4'd5, SB_MWR, 2'b00, 3'b000);
        push(1'b1, 1'b0, 4'd5, SB_MWR, 2'b00, 3'b000);
        run_q("sw");
        n_retired++;

        // jal: JAL then ALUWB
        set_instr(32'h008000ef);
        check("jal imm_src", 32'(bus.imm_src), 32'd3);
        push_fetch(0);
        push(1'b1, 1'b0, 4'd10, SB_PCW, 2'b00, 3'b000);
        push(1'b1, 1'b0, 4'd8, SB_WB, 2'b00, 3'b000);
        run_q("jal");
        n_retired++;
`ifdef RETIRE_CNT_EN
        check("instret", bus.instret, 32'(n_retired));
`endif

        // illegal opcode traps and stays trapped; retire count frozen
        set_instr(32'h0000007f);
        push_fetch(0);
        push(1'b0, 1'b0, 4'd15, SB_TRAP, 2'b00, 3'b000);
        push(1'b1, 1'b0, 4'd15, SB_TRAP, 2'b00, 3'b000);
        run_q("illegal");
`ifdef RETIRE_CNT_EN
        check("instret after trap", bus.instret, 32'(n_retired));
`endif
        do_reset();

        // R-type with illegal funct3, and beq with funct3 != 000
        set_instr(32'h00629233);
        push_fetch(0);
        push(1'b1, 1'b0, 4'd15, SB_TRAP, 2'b00, 3'b000);
        run_q("sll");
        do_reset();
        set_instr(32'h00001463);
        push_fetch(0);
        push(1'b1, 1'b0, 4'd15, SB_TRAP, 2'b00, 3'b000);
        run_q("bne");
        do_reset();

        // watchdog: 16 FETCH stalls then TRAP with mem_req dropped
        set_instr(32'h00628233);
        for (int i = 0; i < 16; i++) push(1'b0, 1'b0, 4'd0, SB_STALL, 2'b10, 3'b000);
        push(1'b0, 1'b0, 4'd15, SB_TRAP, 2'b00, 3'b000);
        push(1'b1, 1'b0, 4'd15, SB_TRAP, 2'b00, 3'b000);
        run_q("timeout");
        do_reset();

        // reset in the middle of a stalled load abandons it
        set_instr(32'h00402283);
        push_fetch(0);
        push(1'b1, 1'b0, 4'd2, SB_NONE, 2'b00, 3'b000);
        push(1'b0, 1'b0, 4'd3, SB_MRD, 2'b00, 3'b000);
        run_q("lw-abort");
        do_reset();

        // normal operation after reset
        r_type("add-post", 32'h00628233, 4'd6, 3'b000, 0);
`ifdef RETIRE_CNT_EN
        check("instret post", bus.instret, 32'(n_retired));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
